das_frame_reader: RTL and testbench



---
 rtl/beamform_pkg.sv | 24 ++
 rtl/das_adder_tree.sv | 84 ++++++++
 rtl/das_frame_reader.sv | 180 ++++++++++++++++++
 tb/tb_das_frame_reader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/beamform_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : beamform_pkg
//  Description : Shared widths, FSM state type and vector types for the
//                16-element delay-and-sum beamformer.
//  Revision    : 1.0 - initial release
// ============================================================================
package beamform_pkg;

    localparam int N_CH    = 16;
    localparam int DELTA_W = 8;
    localparam int ADDR_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef logic [N_CH-1:0][DELTA_W-1:0] delta_vec_t;
    typedef logic [N_CH-1:0][ADDR_W-1:0]  addr_vec_t;

endpackage
`default_nettype wire

// File: rtl/das_adder_tree.sv
`default_nettype none
// ============================================================================
//  Module      : das_adder_tree
//  Description : 16-input signed two-stage registered adder with enable,
//                carrying a valid bit and the pixel coordinate tag alongside.
//  Revision    : 1.0 - initial release
// ============================================================================
module das_adder_tree
    import beamform_pkg::*;
#(
    parameter int SAMPLE_W = 12,
    parameter int XW       = 6,
    parameter int YW       = 6
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_en,
    input  logic                          i_valid,
    input  logic signed [XW-1:0]          i_x,
    input  logic signed [YW-1:0]          i_y,
    input  logic [N_CH-1:0][SAMPLE_W-1:0] i_data,
    output logic                          o_valid,
    output logic signed [XW-1:0]          o_x,
    output logic signed [YW-1:0]          o_y,
    output logic signed [SAMPLE_W+3:0]    o_sum
);

    localparam int c_groups = N_CH / 4;
    localparam int c_part_w = SAMPLE_W + 2;
    localparam int c_sum_w  = SAMPLE_W + 4;

    logic signed [c_part_w-1:0] w_part [c_groups];
    logic signed [c_part_w-1:0] r_part [c_groups];
    logic signed [c_sum_w-1:0]  w_sum;
    logic                       r_valid_a;
    logic signed [XW-1:0]       r_x_a;
    logic signed [YW-1:0]       r_y_a;

    always_comb begin
        for (int g = 0; g < c_groups; g++) begin
            w_part[g] = '0;
            for (int j = 0; j < 4; j++) begin
                w_part[g] = w_part[g] + c_part_w'($signed(i_data[4*g+j]));
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int g = 0; g < c_groups; g++) r_part[g] <= '0;
            r_valid_a <= 1'b0;
            r_x_a     <= '0;
            r_y_a     <= '0;
        end else if (i_en) begin
            for (int g = 0; g < c_groups; g++) r_part[g] <= w_part[g];
            r_valid_a <= i_valid;
            r_x_a     <= i_x;
            r_y_a     <= i_y;
        end
    end

    always_comb begin
        w_sum = '0;
        for (int g = 0; g < c_groups; g++) begin
            w_sum = w_sum + c_sum_w'(r_part[g]);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_x     <= '0;
            o_y     <= '0;
            o_sum   <= '0;
        end else if (i_en) begin
            o_valid <= r_valid_a;
            o_x     <= r_x_a;
            o_y     <= r_y_a;
            o_sum   <= w_sum;
        end
    end

endmodule
`default_nettype wire

// File: rtl/das_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module      : das_frame_reader
//  Description : Raster pixel scan, per-channel read addressing and 16-way
//                delay-and-sum with a valid/ready pixel output stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module das_frame_reader
    import beamform_pkg::*;
#(
    parameter int COLS     = 64,
    parameter int ROWS     = 64,
    parameter int SAMPLE_W = 12
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_start,
    input  logic [7:0]                     i_t0,
    output logic                           o_busy,
    output logic signed [$clog2(COLS)-1:0] o_p_x,
    output logic signed [$clog2(ROWS)-1:0] o_p_y,
    input  delta_vec_t                     i_delta,
    output addr_vec_t                      o_rd_addr,
    input  logic [N_CH-1:0][SAMPLE_W-1:0]  i_rd_data,
    output logic                           o_pix_valid,
    input  logic                           i_pix_ready,
    output logic signed [SAMPLE_W+3:0]     o_pix_data,
    output logic signed [$clog2(COLS)-1:0] o_pix_x,
    output logic signed [$clog2(ROWS)-1:0] o_pix_y,
    output logic                           o_frame_done
);

    localparam int c_xw = $clog2(COLS);
    localparam int c_yw = $clog2(ROWS);
    localparam logic signed [c_xw-1:0] c_x_min = {1'b1, {(c_xw-1){1'b0}}};
    localparam logic signed [c_xw-1:0] c_x_max = {1'b0, {(c_xw-1){1'b1}}};
    localparam logic signed [c_yw-1:0] c_y_min = {1'b1, {(c_yw-1){1'b0}}};
    localparam logic signed [c_yw-1:0] c_y_max = {1'b0, {(c_yw-1){1'b1}}};

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic signed [c_xw-1:0]        r_px;
    logic signed [c_yw-1:0]        r_py;
    logic [7:0]                    r_t0;
    logic                          w_en;
    logic                          w_accept;
    logic                          w_issue;
    logic                          w_done;
    logic                          w_last_hs;
    addr_vec_t                     r_rd_addr;
    logic                          r_v1;
    logic signed [c_xw-1:0]        r_x1;
    logic signed [c_yw-1:0]        r_y1;
    logic                          r_v2;
    logic signed [c_xw-1:0]        r_x2;
    logic signed [c_yw-1:0]        r_y2;
    logic                          r_en_d;
    logic [N_CH-1:0][SAMPLE_W-1:0] r_data_hold;
    logic [N_CH-1:0][SAMPLE_W-1:0] w_data;
    logic                          r_frame_done;

    assign w_en      = !(o_pix_valid && !i_pix_ready);
    assign w_last_hs = o_pix_valid && i_pix_ready &&
                       (o_pix_x == c_x_max) && (o_pix_y == c_y_max);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (w_en) begin
                    w_issue = 1'b1;
                    if (r_px == c_x_max && r_py == c_y_max) w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_last_hs) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_px <= c_x_min;
            r_py <= c_y_min;
            r_t0 <= '0;
        end else if (w_accept) begin
            r_px <= c_x_min;
            r_py <= c_y_min;
            r_t0 <= i_t0;
        end else if (w_issue) begin
            r_px <= r_px + c_xw'(1);
            if (r_px == c_x_max) r_py <= r_py + c_yw'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_addr <= '0;
            r_v1      <= 1'b0;
            r_x1      <= '0;
            r_y1      <= '0;
            r_v2      <= 1'b0;
            r_x2      <= '0;
            r_y2      <= '0;
        end else if (w_en) begin
            for (int k = 0; k < N_CH; k++) begin
                r_rd_addr[k] <= i_delta[k] + r_t0;
            end
            r_v1 <= w_issue;
            r_x1 <= r_px;
            r_y1 <= r_py;
            r_v2 <= r_v1;
            r_x2 <= r_x1;
            r_y2 <= r_y1;
        end
    end

    // After the first stall cycle the buffers already return data for the
    // held address, so the sample set belonging to stage 2 is kept aside.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_en_d      <= 1'b1;
            r_data_hold <= '0;
        end else begin
            r_en_d <= w_en;
            if (r_en_d) r_data_hold <= i_rd_data;
        end
    end

    assign w_data = r_en_d ? i_rd_data : r_data_hold;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_frame_done <= 1'b0;
        else          r_frame_done <= w_done;
    end

    das_adder_tree #(
        .SAMPLE_W (SAMPLE_W),
        .XW       (c_xw),
        .YW       (c_yw)
    ) u_adder_tree (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_en     (w_en),
        .i_valid  (r_v2),
        .i_x      (r_x2),
        .i_y      (r_y2),
        .i_data   (w_data),
        .o_valid  (o_pix_valid),
        .o_x      (o_pix_x),
        .o_y      (o_pix_y),
        .o_sum    (o_pix_data)
    );

    assign o_busy       = (r_state != IDLE);
    assign o_p_x        = r_px;
    assign o_p_y        = r_py;
    assign o_rd_addr    = r_rd_addr;
    assign o_frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_das_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_das_frame_reader
//  Description : Scoreboard bench for das_frame_reader on a 4x4 image.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_das_frame_reader;
    import beamform_pkg::*;

    localparam int COLS = 4;
    localparam int ROWS = 4;
    localparam int SW   = 12;

    typedef struct {
        int x;
        int y;
        int data;
    } pix_t;

    logic                    clk       = 1'b0;
    logic                    rst_n     = 1'b0;
    logic                    start     = 1'b0;
    logic                    pix_ready = 1'b1;
    logic [7:0]              t0        = 8'd0;
    logic                    busy;
    logic signed [1:0]       p_x, p_y, pix_x, pix_y;
    delta_vec_t              delta;
    addr_vec_t               rd_addr;
    logic [N_CH-1:0][SW-1:0] rd_data = '0;
    logic [N_CH-1:0][SW-1:0] rd_nxt;
    logic                    pix_valid;
    logic signed [SW+3:0]    pix_data;
    logic                    frame_done;

    int         delta_mode  = 0;
    int         data_mode   = 0;
    logic [7:0] delta_const = 8'd0;
    logic [SW-1:0] data_const = '0;

    int cyc = 0, n_vec = 0, n_miss = 0, n_pop = 0, n_done = 0, done_cyc = 0;
    pix_t sb[$];

    das_frame_reader #(.COLS(COLS), .ROWS(ROWS), .SAMPLE_W(SW)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_t0         (t0),
        .o_busy       (busy),
        .o_p_x        (p_x),
        .o_p_y        (p_y),
        .i_delta      (delta),
        .o_rd_addr    (rd_addr),
        .i_rd_data    (rd_data),
        .o_pix_valid  (pix_valid),
        .i_pix_ready  (pix_ready),
        .o_pix_data   (pix_data),
        .o_pix_x      (pix_x),
        .o_pix_y      (pix_y),
        .o_frame_done (frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] delta_fn(int k, int x, int y);
        return 8'(x * 13 + y * 29 + k * 11 + 200);
    endfunction

    function automatic logic [SW-1:0] data_fn(int k, logic [7:0] a);
        return SW'(int'(a) * 5 - 600 + k * 3);
    endfunction

    // Delta generator and channel buffers (one-cycle read latency)
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            delta[k] = (delta_mode == 0) ? delta_fn(k, int'(p_x), int'(p_y)) : delta_const;
            rd_nxt[k] = (data_mode == 0) ? data_fn(k, rd_addr[k]) : data_const;
        end
    end
    always @(posedge clk) rd_data <= rd_nxt;

    function automatic int exp_sum(int x, int y);
        int s = 0;
        logic [7:0] a;
        logic [SW-1:0] d;
        for (int k = 0; k < N_CH; k++) begin
            a = ((delta_mode == 0) ? delta_fn(k, x, y) : delta_const) + t0;
            d = (data_mode == 0) ? data_fn(k, a) : data_const;
            s += int'($signed(d));
        end
        return s;
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_miss++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (pix_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_pixel", 1, 0);
                end else begin
                    check("pix_x", pix_x, sb[0].x);
                    check("pix_y", pix_y, sb[0].y);
                    check("pix_data", pix_data, sb[0].data);
                    if (pix_ready) begin
                        void'(sb.pop_front());
                        n_pop++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(output int s);
        for (int y = -ROWS / 2; y < ROWS / 2; y++)
            for (int x = -COLS / 2; x < COLS / 2; x++)
                sb.push_back('{x: x, y: y, data: exp_sum(x, y)});
        start = 1'b1;
        s = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_frame(input string name, input int p0, input int d0);
        int n = 0;
        while (n_done == d0 && n < 100) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check({name, "_done_pulses"}, n_done - d0, 1);
        check({name, "_pix_count"}, n_pop - p0, COLS * ROWS);
        check({name, "_sb_empty"}, sb.size(), 0);
        check({name, "_busy_idle"}, busy, 0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s, p0, d0, n;
        logic [7:0] a;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", pix_valid, 0);
        check("rst_done", frame_done, 0);
        check("rst_data", pix_data, 0);
        check("rst_pix_x", pix_x, 0);
        check("rst_pix_y", pix_y, 0);
        check("rst_p_x", p_x, -2);
        check("rst_p_y", p_y, -2);
        check("rst_addr0", rd_addr[0], 0);
        check("rst_addr15", rd_addr[15], 0);
        rst_n = 1'b1;
        tick();

        // All samples 1: every pixel sums to 16, latency and frame length
        data_mode = 1; data_const = SW'(1); delta_mode = 0; t0 = 8'd5;
        p0 = n_pop; d0 = n_done;
        start_frame(s);
        check("busy_scan", busy, 1);
        n = 0;
        while (!pix_valid && n < 20) begin
            tick();
            n++;
        end
        check("first_latency", cyc - s, 5);
        check("first_data", pix_data, 16);
        finish_frame("ones", p0, d0);
        check("done_cycle", done_cyc - s, 21);

        // Address rule, plain and wrapping
        delta_mode = 1; delta_const = 8'd147; t0 = 8'd0; data_const = '0;
        p0 = n_pop; d0 = n_done;
        start_frame(s);
        tick();
        for (int k = 0; k < N_CH; k++) check("addr_147", rd_addr[k], 147);
        finish_frame("addr_a", p0, d0);
        delta_const = 8'd179; t0 = 8'd120;
        p0 = n_pop; d0 = n_done;
        start_frame(s);
        tick();
        for (int k = 0; k < N_CH; k++) check("addr_wrap", rd_addr[k], 43);
        finish_frame("addr_b", p0, d0);

        // Back-pressure for 5 cycles while the third pixel is valid
        delta_mode = 0; data_mode = 0; t0 = 8'd33;
        p0 = n_pop; d0 = n_done;
        start_frame(s);
        repeat (6) tick();
        check("stall_valid", pix_valid, 1);
        check("stall_pops", n_pop - p0, 2);
        pix_ready = 1'b0;
        repeat (5) begin
            for (int k = 0; k < N_CH; k++) begin
                a = delta_fn(k, -1, -1) + t0;
                check("stall_addr", rd_addr[k], a);
            end
            check("stall_p_x", p_x, 0);
            check("stall_p_y", p_y, -1);
            tick();
        end
        pix_ready = 1'b1;
        finish_frame("stall", p0, d0);

        // Extreme sample values
        delta_mode = 1; delta_const = 8'd10; data_mode = 1; data_const = 12'h800;
        p0 = n_pop; d0 = n_done;
        start_frame(s);
        finish_frame("neg_full", p0, d0);
        data_const = 12'h7FF;
        p0 = n_pop; d0 = n_done;
        start_frame(s);
        finish_frame("pos_full", p0, d0);

        // Start pulses during SCAN and during DRAIN are ignored
        delta_mode = 0; data_mode = 0; t0 = 8'd200;
        p0 = n_pop; d0 = n_done;
        start_frame(s);
        repeat (2) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (13) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_frame("start_ignored", p0, d0);
        repeat (10) tick();
        check("start_ignored_no_extra", n_done - d0, 1);

        // Asynchronous reset in the middle of a scan
        t0 = 8'd7;
        p0 = n_pop; d0 = n_done;
        start_frame(s);
        repeat (7) tick();
        check("pre_reset_pops", n_pop - p0, 3);
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_valid", pix_valid, 0);
        check("arst_p_x", p_x, -2);
        check("arst_p_y", p_y, -2);
        check("arst_addr", rd_addr[3], 0);
        check("arst_data", pix_data, 0);
        sb.delete();
        tick();
        rst_n = 1'b1;
        repeat (25) tick();
        check("arst_no_done", n_done - d0, 0);
        check("arst_idle", busy, 0);
        p0 = n_pop; d0 = n_done;
        start_frame(s);
        finish_frame("rescan", p0, d0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
